// File: rtl/ysyx_23060061_lsu.sv
// ysyx_23060061_lsu: load/store unit between the core and a simple
// valid/ready memory bus. It holds one request at a time: IDLE -> REQ -> (WAIT) -> RESP.
// Optional feature macro: YSYX_23060061_MISALIGN_CHECK_EN. When it is defined,
// misaligned halfword/word accesses skip the bus and respond at once with misalign=1.
module ysyx_23060061_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  MemRW,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [31:0] r_rdata;
  logic        w_accept;
  logic        w_we_in;
  logic        w_mis_in;

  // Pick the addressed byte/halfword out of the bus word and extend it.
  function automatic logic [31:0] f_load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  f_load_ext = {{24{b[7]}}, b};
      3'b100:  f_load_ext = {24'd0, b};
      3'b001:  f_load_ext = {{16{h[15]}}, h};
      3'b101:  f_load_ext = {16'd0, h};
      default: f_load_ext = word;
    endcase
  endfunction

  // Byte strobes for a store; unknown sizes are treated as full-word stores.
  function automatic logic [3:0] f_store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  f_store_mask = 4'b0001 << off;
      3'b001:  f_store_mask = off[1] ? 4'b1100 : 4'b0011;
      default: f_store_mask = 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data across lanes so the mask alone selects the target.
  function automatic logic [31:0] f_store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  f_store_data = {4{wd[7:0]}};
      3'b001:  f_store_data = {2{wd[15:0]}};
      default: f_store_data = wd;
    endcase
  endfunction

`ifdef YSYX_23060061_MISALIGN_CHECK_EN
  logic r_misalign;

  // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never misalign.
  function automatic logic f_misaligned(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
    if (f3 == 3'b001 || (!we && f3 == 3'b101))
      f_misaligned = off[0];
    else if (f3 == 3'b000 || (!we && f3 == 3'b100))
      f_misaligned = 1'b0;
    else
      f_misaligned = (off != 2'b00);
  endfunction

  assign w_mis_in = f_misaligned(w_we_in, funct3, addr[1:0]);
  assign misalign = r_misalign;

  // Misalign flag is captured with the request and held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_misalign <= 1'b0;
    else if (w_accept) r_misalign <= w_mis_in;
  end
`else
  assign w_mis_in = 1'b0;
  assign misalign = 1'b0;
`endif

  assign w_we_in  = (MemRW == 2'b01);
  assign w_accept = (r_state == S_IDLE) && req_valid && (MemRW == 2'b10 || MemRW == 2'b01);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: writes skip WAIT; stray mem_rvalid outside WAIT is ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)      w_next = w_mis_in ? S_RESP : S_REQ;
      S_REQ:   if (mem_req_ready) w_next = r_we ? S_RESP : S_WAIT;
      S_WAIT:  if (mem_rvalid)    w_next = S_RESP;
      S_RESP:  if (resp_ready)    w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  // Request fields latched on accept; load data captured when the bus returns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= 32'd0;
      r_funct3 <= 3'd0;
      r_wdata  <= 32'd0;
      r_we     <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      if (w_accept) begin
        r_addr   <= addr;
        r_funct3 <= funct3;
        r_wdata  <= wdata;
        r_we     <= w_we_in;
        r_rdata  <= 32'd0;
      end
      if (r_state == S_WAIT && mem_rvalid)
        r_rdata <= f_load_ext(r_funct3, r_addr[1:0], mem_rdata);
    end
  end

  // req_ready is gated by rst_n so it stays low while reset is held.
  assign req_ready     = rst_n && (r_state == S_IDLE);
  assign resp_valid    = (r_state == S_RESP);
  assign rdata         = r_rdata;
  assign mem_req_valid = (r_state == S_REQ);
  assign mem_we        = mem_req_valid && r_we;
  assign mem_addr      = {r_addr[31:2], 2'b00};
  assign mem_wdata     = f_store_data(r_funct3, r_wdata);
  assign mem_wmask     = mem_we ? f_store_mask(r_funct3, r_addr[1:0]) : 4'b0000;

endmodule

// File: tb/tb_ysyx_23060061_lsu.sv
// Scoreboard bench for ysyx_23060061_lsu: directed requests push expected
// responses; a monitor pops and compares on every resp_valid/resp_ready handshake.
module tb_ysyx_23060061_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  MemRW = 2'b00;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        m;
  } exp_t;
  exp_t q[$];

  ysyx_23060061_lsu dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .MemRW(MemRW), .funct3(funct3), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .rdata(rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got rdata=%h misalign=%0b expected no response", rdata, misalign);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_rdata", rdata, e.d);
        chk("resp_misalign", {31'd0, misalign}, {31'd0, e.m});
      end
    end
  end

  // Present one request in IDLE; leaves the bench 1ns into the following cycle.
  task automatic issue(input logic [1:0] rw, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic push, input logic [31:0] ed,
                       input logic em);
    @(posedge clk); #1;
    req_valid = 1'b1; MemRW = rw; funct3 = f3; addr = a; wdata = wd;
    if (push) q.push_back('{d: ed, m: em});
    @(negedge clk);
    chk("req_ready_at_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; MemRW = 2'b00; funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
  endtask

  // Bus request phase: hold off mem_req_ready for 'dly' cycles, then handshake.
  task automatic bus_req(input int dly, input logic we, input logic [31:0] ea,
                         input logic [31:0] ewd, input logic [3:0] emask);
    for (int i = 0; i < dly; i++) begin
      mem_req_ready = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;  // stray data outside WAIT
      @(negedge clk);
      chk("mem_req_valid_hold", {31'd0, mem_req_valid}, 32'd1);
      chk("mem_addr_hold", mem_addr, ea);
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("mem_we", {31'd0, mem_we}, {31'd0, we});
    chk("mem_addr", mem_addr, ea);
    if (we) chk("mem_wdata", mem_wdata, ewd);
    chk("mem_wmask", {28'd0, mem_wmask}, {28'd0, emask});
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
  endtask

  // Read data phase: mem_rvalid after 'dly' idle WAIT cycles.
  task automatic bus_rd(input int dly, input logic [31:0] word);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("wait_no_resp", {31'd0, resp_valid}, 32'd0);
      chk("wait_wmask_zero", {28'd0, mem_wmask}, 32'd0);
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b1; mem_rdata = word;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = $urandom;
  endtask

  // Expect resp_valid in the current cycle, then move on.
  task automatic resp_now(input string name);
    @(negedge clk);
    chk(name, {31'd0, resp_valid}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Bounded drain of the scoreboard.
  task automatic drain();
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL resp_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Idle commands are ignored; stray mem_rvalid in IDLE too
    issue(2'b00, 3'b010, 32'h80000000, 32'h1, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    chk("idle00_no_bus", {31'd0, mem_req_valid}, 32'd0);
    chk("idle00_ready", {31'd0, req_ready}, 32'd1);
    issue(2'b11, 3'b010, 32'h80000000, 32'h1, 1'b0, 32'd0, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("idle11_no_bus", {31'd0, mem_req_valid}, 32'd0);
    chk("idle11_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;

    // lb / lbu at byte 3
    issue(2'b10, 3'b000, 32'h80000003, 32'd0, 1'b1, 32'hFFFFFF80, 1'b0);
    bus_req(0, 1'b0, 32'h80000000, 32'd0, 4'b0000);
    bus_rd(0, 32'h80FF1234);
    resp_now("lb_latency");
    drain();
    issue(2'b10, 3'b100, 32'h80000003, 32'd0, 1'b1, 32'h00000080, 1'b0);
    bus_req(0, 1'b0, 32'h80000000, 32'd0, 4'b0000);
    bus_rd(0, 32'h80FF1234);
    resp_now("lbu_latency");
    drain();

    // lh upper half, lhu lower half
    issue(2'b10, 3'b001, 32'h80000002, 32'd0, 1'b1, 32'hFFFF80FF, 1'b0);
    bus_req(0, 1'b0, 32'h80000000, 32'd0, 4'b0000);
    bus_rd(1, 32'h80FF1234);
    resp_now("lh_resp");
    drain();
    issue(2'b10, 3'b101, 32'h80000010, 32'd0, 1'b1, 32'h00009234, 1'b0);
    bus_req(0, 1'b0, 32'h80000010, 32'd0, 4'b0000);
    bus_rd(0, 32'h80FF9234);
    resp_now("lhu_resp");
    drain();

    // lw with delayed bus handshake and delayed data
    issue(2'b10, 3'b010, 32'h80000004, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0);
    bus_req(3, 1'b0, 32'h80000004, 32'd0, 4'b0000);
    bus_rd(2, 32'hDEADBEEF);
    resp_now("lw_delayed_resp");
    drain();

    // sh: two-cycle write latency, replicated data, upper mask
    issue(2'b01, 3'b001, 32'h80000002, 32'h0000BEEF, 1'b1, 32'd0, 1'b0);
    bus_req(0, 1'b1, 32'h80000000, 32'hBEEFBEEF, 4'b1100);
    resp_now("sh_latency");
    drain();
    issue(2'b01, 3'b000, 32'h80000001, 32'h123456A5, 1'b1, 32'd0, 1'b0);
    bus_req(0, 1'b1, 32'h80000000, 32'hA5A5A5A5, 4'b0010);
    resp_now("sb_resp");
    drain();
    issue(2'b01, 3'b010, 32'h80000008, 32'hCAFEF00D, 1'b1, 32'd0, 1'b0);
    bus_req(1, 1'b1, 32'h80000008, 32'hCAFEF00D, 4'b1111);
    resp_now("sw_resp");
    drain();

    // Core back-pressure: resp_ready low for 4 cycles
    resp_ready = 1'b0;
    issue(2'b10, 3'b010, 32'h8000000C, 32'd0, 1'b1, 32'h01234567, 1'b0);
    bus_req(0, 1'b0, 32'h8000000C, 32'd0, 4'b0000);
    bus_rd(0, 32'h01234567);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_rdata", rdata, 32'h01234567);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_req_ready_hs", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_req_ready_after", {31'd0, req_ready}, 32'd1);
    drain();

    // Reset while in WAIT, then a late mem_rvalid
    issue(2'b10, 3'b010, 32'h80000020, 32'd0, 1'b0, 32'd0, 1'b0);
    bus_req(0, 1'b0, 32'h80000020, 32'd0, 4'b0000);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("midrst_still_ready", {31'd0, req_ready}, 32'd1);

    // Misaligned lw at 0x80000001
`ifdef YSYX_23060061_MISALIGN_CHECK_EN
    issue(2'b10, 3'b010, 32'h80000001, 32'd0, 1'b1, 32'd0, 1'b1);
    @(negedge clk);
    chk("mis_no_bus", {31'd0, mem_req_valid}, 32'd0);
    chk("mis_resp_valid", {31'd0, resp_valid}, 32'd1);
    @(posedge clk); #1;
    drain();
`else
    issue(2'b10, 3'b010, 32'h80000001, 32'd0, 1'b1, 32'hA1B2C3D4, 1'b0);
    bus_req(0, 1'b0, 32'h80000000, 32'd0, 4'b0000);
    bus_rd(0, 32'hA1B2C3D4);
    resp_now("mis_off_resp");
    drain();
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
